// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage (package fetch_pkg).
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH_BOOT  = 2'd0,
    FETCH_RUN   = 2'd1,
    FETCH_FAULT = 2'd2
  } fetch_state_e;

  // sll $0,$0,0 encodes as all zeros.
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INC            = 32'd4;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory bus: the fetch unit drives a word address, memory answers combinationally.
interface if_fetch_unit_if #(
  parameter int IMEM_AW = 8
);
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_data;

  modport master (output imem_addr, input imem_data);
  modport slave  (input imem_addr, output imem_data);
endinterface

// File: rtl/if_fetch_unit_id_reg.sv
// IF/ID pipeline register: flush beats load, load beats hold; flush keeps pc fields.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] pc_plus4_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o
);

  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic [31:0] pc_plus4_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      instr_q    <= NOP_INSTR;
      pc_q       <= 32'h0;
      pc_plus4_q <= 32'h0;
    end else if (flush_i) begin
      valid_q    <= 1'b0;
      instr_q    <= NOP_INSTR;
    end else if (load_i) begin
      valid_q    <= 1'b1;
      instr_q    <= instr_i;
      pc_q       <= pc_i;
      pc_plus4_q <= pc_plus4_i;
    end
  end

  assign valid_o    = valid_q;
  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch unit: owns the PC, fetches from imem, fills IF/ID, handles stall/redirect/fault.
// Optional counters under `IF_FETCH_PERF_EN.
module if_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          IMEM_AW   = 8,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  if_fetch_unit_if.master       imem,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_target,
  output logic                  if_valid,
  output logic [31:0]           if_instr,
  output logic [31:0]           if_pc,
  output logic [31:0]           if_pc_plus4,
  output logic                  fault,
  output logic [31:0]           fault_addr,
  output fetch_state_e          dbg_state
`ifdef IF_FETCH_PERF_EN
  , output logic [31:0]         perf_fetch_count
  , output logic [31:0]         perf_flush_count
`endif
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic         fault_q;
  logic [31:0]  fault_addr_q;

  logic active;
  logic bad_target;
  logic load;
  logic flush;

  // BOOT accepts redirects but never captures; FAULT ignores everything.
  assign active     = (state_q == FETCH_BOOT) || (state_q == FETCH_RUN);
  assign bad_target = is_misaligned(redirect_target);
  assign flush      = active && redirect_valid;
  assign load       = (state_q == FETCH_RUN) && !redirect_valid && !stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FETCH_BOOT;
      pc_q         <= RESET_PC;
      fault_q      <= 1'b0;
      fault_addr_q <= 32'h0;
    end else begin
      case (state_q)
        FETCH_BOOT, FETCH_RUN: begin
          if (redirect_valid && bad_target) begin
            state_q      <= FETCH_FAULT;
            fault_q      <= 1'b1;
            fault_addr_q <= redirect_target;
          end else begin
            state_q <= FETCH_RUN;
            if (redirect_valid) begin
              pc_q <= redirect_target;
            end else if (load) begin
              pc_q <= pc_q + PC_INC;
            end
          end
        end
        FETCH_FAULT: state_q <= FETCH_FAULT;
        default:     state_q <= FETCH_BOOT;
      endcase
    end
  end

  assign imem.imem_addr = pc_q[IMEM_AW+1:2];
  assign fault          = fault_q;
  assign fault_addr     = fault_addr_q;
  assign dbg_state      = state_q;

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load),
    .flush_i    (flush),
    .instr_i    (imem.imem_data),
    .pc_i       (pc_q),
    .pc_plus4_i (pc_q + PC_INC),
    .valid_o    (if_valid),
    .instr_o    (if_instr),
    .pc_o       (if_pc),
    .pc_plus4_o (if_pc_plus4)
  );

`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_fetch_q;
  logic [31:0] perf_flush_q;

  // Only aligned redirects that throw away a live IF/ID entry count as flushes.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch_q <= 32'h0;
      perf_flush_q <= 32'h0;
    end else begin
      if (load) perf_fetch_q <= perf_fetch_q + 32'd1;
      if (flush && !bad_target && if_valid) perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_fetch_count = perf_fetch_q;
  assign perf_flush_count = perf_flush_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a stimulus table plus hand-written reset/wrap/counter sequences.
module tb_if_fetch_unit;
  import fetch_pkg::*;

  // Clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;

  if_fetch_unit_if #(.IMEM_AW(8)) bus ();
  if_fetch_unit_if #(.IMEM_AW(8)) bus2 ();

  // Instruction memory model: word at address a is 0x1000_0000 + a.
  assign bus.imem_data  = 32'h1000_0000 + {24'h0, bus.imem_addr};
  assign bus2.imem_data = 32'h1000_0000 + {24'h0, bus2.imem_addr};

  logic         if_valid, fault;
  logic [31:0]  if_instr, if_pc, if_pc_plus4, fault_addr;
  fetch_state_e st;
  logic         if_valid2, fault2;
  logic [31:0]  if_instr2, if_pc2, if_pc_plus42, fault_addr2;
  fetch_state_e st2;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] pf_fetch, pf_flush, pf_fetch2, pf_flush2;
`endif

  if_fetch_unit dut (
    .clk(clk), .reset(reset), .imem(bus.master),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4),
    .fault(fault), .fault_addr(fault_addr), .dbg_state(st)
`ifdef IF_FETCH_PERF_EN
    , .perf_fetch_count(pf_fetch), .perf_flush_count(pf_flush)
`endif
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .reset(reset), .imem(bus2.master),
    .stall(1'b0), .redirect_valid(1'b0), .redirect_target(32'h0),
    .if_valid(if_valid2), .if_instr(if_instr2), .if_pc(if_pc2), .if_pc_plus4(if_pc_plus42),
    .fault(fault2), .fault_addr(fault_addr2), .dbg_state(st2)
`ifdef IF_FETCH_PERF_EN
    , .perf_fetch_count(pf_fetch2), .perf_flush_count(pf_flush2)
`endif
  );

  // Scoreboard counters
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        s;
    logic        rv;
    logic [31:0] tgt;
    logic        v;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [7:0]  addr;
    logic        f;
    logic [31:0] fa;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic rv, input logic [31:0] tgt,
                              input logic v, input logic [31:0] instr, input logic [31:0] pc,
                              input logic [31:0] pc4, input logic [7:0] addr,
                              input logic f, input logic [31:0] fa);
    vec_t r;
    r.s = s; r.rv = rv; r.tgt = tgt; r.v = v; r.instr = instr;
    r.pc = pc; r.pc4 = pc4; r.addr = addr; r.f = f; r.fa = fa;
    return r;
  endfunction

  vec_t vecs[16];

  initial begin
    // Inputs applied for one cycle; expected outputs just after that edge.
    vecs[0]  = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         32'h0,   32'h0,   8'h00, 1'b0, 32'h0);
    vecs[1]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h1000_0000, 32'h0,   32'h4,   8'h01, 1'b0, 32'h0);
    vecs[2]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h1000_0001, 32'h4,   32'h8,   8'h02, 1'b0, 32'h0);
    vecs[3]  = mk(1'b1, 1'b0, 32'h0,   1'b1, 32'h1000_0001, 32'h4,   32'h8,   8'h02, 1'b0, 32'h0);
    vecs[4]  = mk(1'b1, 1'b0, 32'h0,   1'b1, 32'h1000_0001, 32'h4,   32'h8,   8'h02, 1'b0, 32'h0);
    vecs[5]  = mk(1'b1, 1'b0, 32'h0,   1'b1, 32'h1000_0001, 32'h4,   32'h8,   8'h02, 1'b0, 32'h0);
    vecs[6]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h1000_0002, 32'h8,   32'hC,   8'h03, 1'b0, 32'h0);
    vecs[7]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h1000_0003, 32'hC,   32'h10,  8'h04, 1'b0, 32'h0);
    vecs[8]  = mk(1'b1, 1'b1, 32'hA0,  1'b0, 32'h0,         32'hC,   32'h10,  8'h28, 1'b0, 32'h0);
    vecs[9]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h1000_0028, 32'hA0,  32'hA4,  8'h29, 1'b0, 32'h0);
    vecs[10] = mk(1'b0, 1'b1, 32'h3FC, 1'b0, 32'h0,         32'hA0,  32'hA4,  8'hFF, 1'b0, 32'h0);
    vecs[11] = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h1000_00FF, 32'h3FC, 32'h400, 8'h00, 1'b0, 32'h0);
    vecs[12] = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h1000_0000, 32'h400, 32'h404, 8'h01, 1'b0, 32'h0);
    vecs[13] = mk(1'b0, 1'b1, 32'h52,  1'b0, 32'h0,         32'h400, 32'h404, 8'h01, 1'b1, 32'h52);
    vecs[14] = mk(1'b1, 1'b1, 32'h100, 1'b0, 32'h0,         32'h400, 32'h404, 8'h01, 1'b1, 32'h52);
    vecs[15] = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         32'h400, 32'h404, 8'h01, 1'b1, 32'h52);

    // Reset state
    reset = 1'b1;
    tick();
    check32("rst_valid", {31'h0, if_valid}, 32'h0);
    check32("rst_instr", if_instr, NOP_INSTR_DEFAULT);
    check32("rst_pc", if_pc, 32'h0);
    check32("rst_pc4", if_pc_plus4, 32'h0);
    check32("rst_addr", {24'h0, bus.imem_addr}, 32'h0);
    check32("rst_fault", {31'h0, fault}, 32'h0);
    check32("rst_state", 32'(st), 32'(FETCH_BOOT));
    reset = 1'b0;

    // Table-driven run: fetch, stall, redirect-over-stall, address wrap, fault.
    for (int i = 0; i < 16; i++) begin
      stall           = vecs[i].s;
      redirect_valid  = vecs[i].rv;
      redirect_target = vecs[i].tgt;
      tick();
      check32($sformatf("v%0d_valid", i), {31'h0, if_valid}, {31'h0, vecs[i].v});
      check32($sformatf("v%0d_instr", i), if_instr, vecs[i].instr);
      check32($sformatf("v%0d_pc", i), if_pc, vecs[i].pc);
      check32($sformatf("v%0d_pc4", i), if_pc_plus4, vecs[i].pc4);
      check32($sformatf("v%0d_addr", i), {24'h0, bus.imem_addr}, {24'h0, vecs[i].addr});
      check32($sformatf("v%0d_fault", i), {31'h0, fault}, {31'h0, vecs[i].f});
      check32($sformatf("v%0d_faddr", i), fault_addr, vecs[i].fa);
    end
    check32("fault_state", 32'(st), 32'(FETCH_FAULT));

    // Reset leaves FAULT and clears the fault record.
    stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    reset = 1'b1;
    tick();
    check32("frst_fault", {31'h0, fault}, 32'h0);
    check32("frst_faddr", fault_addr, 32'h0);
    check32("frst_addr", {24'h0, bus.imem_addr}, 32'h0);
    check32("frst_state", 32'(st), 32'(FETCH_BOOT));
    reset = 1'b0;

    // BOOT edge, then first capture; dut2 starts at 0xFFFF_FFFC and wraps.
    tick();
    check32("boot_valid", {31'h0, if_valid}, 32'h0);
    check32("boot2_valid", {31'h0, if_valid2}, 32'h0);
    tick();
    check32("cap_valid", {31'h0, if_valid}, 32'h1);
    check32("cap_instr", if_instr, 32'h1000_0000);
    check32("w2_valid", {31'h0, if_valid2}, 32'h1);
    check32("w2_pc", if_pc2, 32'hFFFF_FFFC);
    check32("w2_pc4", if_pc_plus42, 32'h0);
    check32("w2_instr", if_instr2, 32'h1000_00FF);
    check32("w2_addr", {24'h0, bus2.imem_addr}, 32'h0);

    // Reset in the middle of a stall still wins.
    stall = 1'b1;
    tick();
    check32("stl_addr", {24'h0, bus.imem_addr}, 32'h1);
    reset = 1'b1;
    tick();
    check32("stlrst_valid", {31'h0, if_valid}, 32'h0);
    check32("stlrst_instr", if_instr, NOP_INSTR_DEFAULT);
    check32("stlrst_addr", {24'h0, bus.imem_addr}, 32'h0);
    reset = 1'b0;
    stall = 1'b0;

`ifdef IF_FETCH_PERF_EN
    // 10 fetches and 2 aligned redirects that each discard a valid entry.
    reset = 1'b1;
    tick();
    check32("perf_rst_fetch", pf_fetch, 32'h0);
    check32("perf_rst_flush", pf_flush, 32'h0);
    reset = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) tick();
    redirect_valid = 1'b1; redirect_target = 32'h40;
    tick();
    redirect_valid = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    redirect_valid = 1'b1; redirect_target = 32'h80;
    tick();
    redirect_valid = 1'b0;
    check32("perf_fetch", pf_fetch, 32'd10);
    check32("perf_flush", pf_flush, 32'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
